// File: rtl/fnd_scan_decoder_if.sv
// Multiplexed 7-segment scan bus: active-low digit select and active-low segments.
// The display driver owns the nets; the scan decoder only observes them.
interface fnd_scan_decoder_if;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    modport master (output fnd_com, output fnd_data);
    modport slave  (input  fnd_com, input  fnd_data);
endinterface

// File: rtl/fnd_scan_decoder.sv
// Passive observer of the 7-segment scan bus. It decodes settled slots, merges them into frames,
// and publishes a debounced 4-digit value with dot flags.
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int FRAME_SLOTS    = 8,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 300_000
) (
    input  logic                     clk,
    input  logic                     reset,
    fnd_scan_decoder_if.slave        bus,
    output logic [15:0]              o_digits,
    output logic [3:0]               o_dots,
    output logic                     o_valid,
    output logic                     o_err,
    output logic                     o_active
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(FRAME_SLOTS + 1);
    localparam int TW = $clog2(STABLE_FRAMES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SLOTS_FULL   = CW'(FRAME_SLOTS);
    localparam logic [TW-1:0] STABLE_MAX   = TW'(STABLE_FRAMES);
    localparam logic [IW-1:0] IDLE_LAST    = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX     = IW'(TIMEOUT_CYCLES);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t          state_reg;
    logic [11:0]     bus_reg;
    logic [SW-1:0]   settle_reg;
    logic [CW-1:0]   slot_cnt_reg;
    logic [TW-1:0]   stable_cnt_reg;
    logic [IW-1:0]   idle_reg;
    logic [3:0][3:0] code_buf_reg;
    logic [3:0]      dot_buf_reg;
    logic [19:0]     prev_frame_reg;
    logic            published_reg;

    logic [11:0]     bus_now;
    logic            same;
    logic            settled;
    logic            com_ok;
    logic [1:0]      pos;
    logic            seg_ok;
    logic [3:0]      code;
    logic            dot;
    logic            accept;
    logic            timeout;
    logic            close;
    logic            publish;
    logic [19:0]     frame_now;
    logic [TW-1:0]   stable_next;

    logic [3:0][3:0] load_code;
    logic [3:0][3:0] merge_code;
    logic [3:0]      load_dot;
    logic [3:0]      merge_dot;

    assign bus_now = {bus.fnd_com, bus.fnd_data};
    assign same    = (bus_now == bus_reg);
    // The counter saturates past SETTLE_LAST, so a held value is sampled exactly once.
    assign settled = same && (settle_reg == SETTLE_LAST);
    assign dot     = ~bus.fnd_data[7];

    always_comb begin
        com_ok = 1'b1;
        pos    = 2'd0;
        case (bus.fnd_com)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: com_ok = 1'b0;
        endcase
    end

    always_comb begin
        seg_ok = 1'b1;
        code   = 4'hF;
        case (bus.fnd_data[6:0])
            7'h40: code = 4'h0;
            7'h79: code = 4'h1;
            7'h24: code = 4'h2;
            7'h30: code = 4'h3;
            7'h19: code = 4'h4;
            7'h12: code = 4'h5;
            7'h02: code = 4'h6;
            7'h78: code = 4'h7;
            7'h00: code = 4'h8;
            7'h10: code = 4'h9;
            7'h08: code = 4'hA;
            7'h03: code = 4'hB;
            7'h46: code = 4'hC;
            7'h21: code = 4'hD;
            7'h7F: code = 4'hF;
            default: seg_ok = 1'b0;
        endcase
    end

    assign accept  = settled && com_ok;
    assign timeout = !accept && (idle_reg == IDLE_LAST);
    assign close   = accept && (state_reg == COLLECT) && (pos == 2'd0) && (slot_cnt_reg >= SLOTS_FULL);

    assign frame_now   = {dot_buf_reg, code_buf_reg};
    // stable_cnt of zero means there is no previous frame to compare against.
    assign stable_next = (stable_cnt_reg != '0 && frame_now == prev_frame_reg)
                         ? ((stable_cnt_reg == STABLE_MAX) ? stable_cnt_reg : stable_cnt_reg + TW'(1))
                         : TW'(1);
    assign publish     = close && (stable_next == STABLE_MAX)
                         && (!published_reg || frame_now != {o_dots, o_digits});

    // Blank or unknown codes never overwrite a real digit; dots accumulate.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pos
            logic hit;
            assign hit            = (pos == 2'(gi));
            assign load_code[gi]  = (hit && code != 4'hF) ? code : 4'hF;
            assign merge_code[gi] = (hit && code != 4'hF) ? code : code_buf_reg[gi];
            assign load_dot[gi]   = hit & dot;
            assign merge_dot[gi]  = dot_buf_reg[gi] | (hit & dot);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= HUNT;
            bus_reg        <= '0;
            settle_reg     <= '0;
            slot_cnt_reg   <= '0;
            stable_cnt_reg <= '0;
            idle_reg       <= '0;
            code_buf_reg   <= {4{4'hF}};
            dot_buf_reg    <= '0;
            prev_frame_reg <= '0;
            published_reg  <= 1'b0;
            o_digits       <= 16'hFFFF;
            o_dots         <= '0;
            o_valid        <= 1'b0;
            o_err          <= 1'b0;
            o_active       <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_err   <= settled && (!com_ok || !seg_ok);
            bus_reg <= bus_now;

            if (!same)
                settle_reg <= '0;
            else if (settle_reg != SETTLE_MAX)
                settle_reg <= settle_reg + SW'(1);

            if (accept) begin
                idle_reg <= '0;
                o_active <= 1'b1;
            end else if (idle_reg != IDLE_MAX) begin
                idle_reg <= idle_reg + IW'(1);
            end

            if (timeout) begin
                o_active       <= 1'b0;
                state_reg      <= HUNT;
                slot_cnt_reg   <= '0;
                stable_cnt_reg <= '0;
                code_buf_reg   <= {4{4'hF}};
                dot_buf_reg    <= '0;
            end else if (accept) begin
                case (state_reg)
                    HUNT: begin
                        if (pos == 2'd0) begin
                            state_reg    <= COLLECT;
                            code_buf_reg <= load_code;
                            dot_buf_reg  <= load_dot;
                            slot_cnt_reg <= CW'(1);
                        end
                    end
                    COLLECT: begin
                        if (close) begin
                            prev_frame_reg <= frame_now;
                            stable_cnt_reg <= stable_next;
                            if (publish) begin
                                {o_dots, o_digits} <= frame_now;
                                o_valid            <= 1'b1;
                                published_reg      <= 1'b1;
                            end
                            code_buf_reg <= load_code;
                            dot_buf_reg  <= load_dot;
                            slot_cnt_reg <= CW'(1);
                        end else begin
                            code_buf_reg <= merge_code;
                            dot_buf_reg  <= merge_dot;
                            if (slot_cnt_reg != SLOTS_FULL)
                                slot_cnt_reg <= slot_cnt_reg + CW'(1);
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: scans, repeats, glitches, errors, timeout and mid-frame reset.
module tb_fnd_scan_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] o_digits;
    logic [3:0]  o_dots;
    logic        o_valid;
    logic        o_err;
    logic        o_active;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(
        .SETTLE_CYCLES (4),
        .FRAME_SLOTS   (8),
        .STABLE_FRAMES (2),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_digits(o_digits),
        .o_dots  (o_dots),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_active(o_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) valid_cnt <= valid_cnt + 1;
        if (o_err)   err_cnt   <= err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic set_bus(input logic [1:0] pos, input logic [7:0] data);
        logic [3:0] one;
        one = 4'b0001;
        bus.fnd_com  = ~(one << pos);
        bus.fnd_data = data;
    endtask

    task automatic drive_slot(input logic [1:0] pos, input logic [7:0] data);
        set_bus(pos, data);
        repeat (30) @(negedge clk);
    endtask

    // Short excursion to 79 mid-slot, too brief to settle.
    task automatic glitch_slot(input logic [1:0] pos, input logic [7:0] data);
        set_bus(pos, data);
        repeat (10) @(negedge clk);
        bus.fnd_data = 8'h79;
        repeat (2) @(negedge clk);
        bus.fnd_data = data;
        repeat (18) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input bit glitch);
        drive_slot(2'd0, d0);
        if (glitch) glitch_slot(2'd1, d1);
        else        drive_slot(2'd1, d1);
        drive_slot(2'd2, d2);
        drive_slot(2'd3, d3);
        drive_slot(2'd0, 8'hFF);
        drive_slot(2'd1, 8'hFF);
        drive_slot(2'd2, 8'h7F);
        drive_slot(2'd3, 8'hFF);
        $display("scan %h %h %h %h glitch=%0d digits=%h dots=%b", d0, d1, d2, d3, glitch, o_digits, o_dots);
    endtask

    task automatic check_reset_values(input string stage);
        check_eq({stage, "_digits"}, 32'(o_digits), 32'hFFFF);
        check_eq({stage, "_dots"},   32'(o_dots),   32'h0);
        check_eq({stage, "_valid"},  32'(o_valid),  32'h0);
        check_eq({stage, "_err"},    32'(o_err),    32'h0);
        check_eq({stage, "_active"}, 32'(o_active), 32'h0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic scan: 5,9,2,0 with the pos2 dot from the blank slot.
        v0 = valid_cnt;
        repeat (3) scan(8'h92, 8'h90, 8'hA4, 8'hC0, 1'b0);
        check_eq("basic_valid", 32'(valid_cnt - v0), 32'd1);
        check_eq("basic_digits", 32'(o_digits), 32'h0295);
        check_eq("basic_dots", 32'(o_dots), 32'h4);
        check_eq("basic_active", 32'(o_active), 32'h1);

        v0 = valid_cnt;
        repeat (5) scan(8'h92, 8'h90, 8'hA4, 8'hC0, 1'b0);
        check_eq("repeat_no_valid", 32'(valid_cnt - v0), 32'd0);

        v0 = valid_cnt;
        repeat (3) scan(8'hF9, 8'h90, 8'hA4, 8'hC0, 1'b0);
        check_eq("change_valid", 32'(valid_cnt - v0), 32'd1);
        check_eq("change_digits", 32'(o_digits), 32'h0291);

        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (3) scan(8'hF9, 8'h90, 8'hA4, 8'hC0, 1'b1);
        check_eq("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("glitch_digits", 32'(o_digits), 32'h0291);
        check_eq("glitch_dots", 32'(o_dots), 32'h4);
        check_eq("glitch_no_err", 32'(err_cnt - e0), 32'd0);

        // Illegal com held long enough to settle.
        e0 = err_cnt;
        bus.fnd_com  = 4'b1100;
        bus.fnd_data = 8'hFF;
        repeat (10) @(negedge clk);
        check_eq("err_com", 32'(err_cnt - e0), 32'd1);

        // Unknown pattern 55 on position 3: decodes to F, its dot bit is low so the dot lights.
        e0 = err_cnt;
        v0 = valid_cnt;
        repeat (3) scan(8'hF9, 8'h90, 8'hA4, 8'h55, 1'b0);
        check_eq("err_pattern", 32'(err_cnt - e0), 32'd3);
        check_eq("err_valid", 32'(valid_cnt - v0), 32'd1);
        check_eq("err_digits", 32'(o_digits), 32'hF291);
        check_eq("err_dots", 32'(o_dots), 32'hC);

        // Timeout: last accept was 26 edges before the stop drive takes effect.
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        repeat (174) @(negedge clk);
        check_eq("timeout_before", 32'(o_active), 32'h1);
        @(negedge clk);
        check_eq("timeout_after", 32'(o_active), 32'h0);
        repeat (20) @(negedge clk);
        check_eq("timeout_hold_digits", 32'(o_digits), 32'hF291);
        check_eq("timeout_hold_dots", 32'(o_dots), 32'hC);

        v0 = valid_cnt;
        drive_slot(2'd2, 8'h00);
        check_eq("resume_active", 32'(o_active), 32'h1);
        drive_slot(2'd3, 8'h00);
        repeat (2) scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b0);
        check_eq("resume_wait", 32'(valid_cnt - v0), 32'd0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b0);
        check_eq("resume_valid", 32'(valid_cnt - v0), 32'd1);
        check_eq("resume_digits", 32'(o_digits), 32'h3210);
        check_eq("resume_dots", 32'(o_dots), 32'h4);

        // Reset during slot 5 of a scan.
        drive_slot(2'd0, 8'hC0);
        drive_slot(2'd1, 8'hF9);
        drive_slot(2'd2, 8'hA4);
        drive_slot(2'd3, 8'hB0);
        drive_slot(2'd0, 8'hFF);
        set_bus(2'd1, 8'hFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        v0 = valid_cnt;
        repeat (2) scan(8'h92, 8'h90, 8'hA4, 8'hC0, 1'b0);
        check_eq("post_rst_wait", 32'(valid_cnt - v0), 32'd0);
        check_eq("post_rst_digits_held", 32'(o_digits), 32'hFFFF);
        scan(8'h92, 8'h90, 8'hA4, 8'hC0, 1'b0);
        check_eq("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
        check_eq("post_rst_digits", 32'(o_digits), 32'h0295);
        check_eq("post_rst_dots", 32'(o_dots), 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
